// File: rtl/chunked_seq_adder_pkg.sv
// adder_pkg: shared FSM state encoding and index-width helper for chunked_seq_adder
package adder_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunked_seq_adder_csa.sv
// carry_select_adder: N-bit slice, low half ripples, high half pre-computed for both carries
//   a, b : N-bit operands   cin : carry in   sum : N-bit result   cout : carry out
module carry_select_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  if (N < 2) begin : g_bit
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  end else begin : g_sel
    localparam int L = N / 2;
    localparam int H = N - L;
    logic [L:0] lo;
    logic [H:0] hi0, hi1;
    assign lo  = {1'b0, a[L-1:0]} + {1'b0, b[L-1:0]} + {{L{1'b0}}, cin};
    assign hi0 = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]};
    assign hi1 = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]} + {{H{1'b0}}, 1'b1};
    assign {cout, sum} = lo[L] ? {hi1, lo[L-1:0]} : {hi0, lo[L-1:0]};
  end
endmodule

// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder: W-bit add performed one CHUNK_W slice per cycle through one slice adder
//   in_valid/in_ready : operand handshake (a, b, cin), accepted only in IDLE
//   out_valid/out_ready : result handshake (sum, cout), result held until taken
//   busy : high while an operation is in flight or awaiting handoff
module chunked_seq_adder
  import adder_pkg::*;
#(
  parameter int CHUNK_W    = 8,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHUNK_W*NUM_CHUNKS-1:0] a,
  input  logic [CHUNK_W*NUM_CHUNKS-1:0] b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHUNK_W*NUM_CHUNKS-1:0] sum,
  output logic                          cout,
  output logic                          busy
);
  localparam int W     = CHUNK_W * NUM_CHUNKS;
  localparam int IDX_W = idx_w(NUM_CHUNKS);
  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CHUNK_W-1:0] s_sum;
  logic               s_cout, last;
  carry_select_adder #(.N(CHUNK_W)) u_slice (
    .a   (a_q[idx_q*CHUNK_W +: CHUNK_W]),
    .b   (b_q[idx_q*CHUNK_W +: CHUNK_W]),
    .cin (carry_q),
    .sum (s_sum),
    .cout(s_cout)
  );
  assign last      = idx_q == IDX_W'(NUM_CHUNKS - 1);
  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign busy      = !in_ready;
  assign sum       = sum_q;
  assign cout      = cout_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == S_IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      idx_d   = '0;
      state_d = S_RUN;
    end
    if (state_q == S_RUN) begin
      sum_d[idx_q*CHUNK_W +: CHUNK_W] = s_sum;
      carry_d = s_cout;
      // wrapping to 0 on the last slice also keeps idx pinned at 0 when NUM_CHUNKS=1
      idx_d   = last ? '0 : idx_q + 1'b1;
      cout_d  = last ? s_cout : cout_q;
      state_d = last ? S_DONE : S_RUN;
    end
    if (state_q == S_DONE && out_ready) state_d = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb_chunked_seq_adder: directed and random checks of chunked_seq_adder (8x4 and 32x1)
module tb_chunked_seq_adder;
  typedef struct {
    logic [32:0] exp;
    int          acc;
  } op_t;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, s0, s1;
  logic [1:0]  ir, ov, bz, co;
  int          checks = 0, passed = 0;
  op_t         q0[$], q1[$];
  always #5 clk = ~clk;
  chunked_seq_adder #(.CHUNK_W(8), .NUM_CHUNKS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[0]), .out_ready(out_ready), .sum(s0), .cout(co[0]), .busy(bz[0])
  );
  chunked_seq_adder #(.CHUNK_W(32), .NUM_CHUNKS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[1]), .out_ready(out_ready), .sum(s1), .cout(co[1]), .busy(bz[1])
  );
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                       output logic [31:0] rs, output logic rc, output int lat);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rs = s0; rc = co[0];
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (ir[0] !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ir[0]); else passed++;
    checks++; if (ov[0] !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ov[0]); else passed++;
    checks++; if (bz[0] !== 1'b0) $display("FAIL reset_busy got %b want 0", bz[0]); else passed++;
    checks++; if (s0 !== 32'h0) $display("FAIL reset_sum got %h want 0", s0); else passed++;
    checks++; if (co[0] !== 1'b0) $display("FAIL reset_cout got %b want 0", co[0]); else passed++;
  endtask
  task automatic test_basic;
    logic [31:0] rs; logic rc; int lat;
    out_ready = 1'b1;
    do_op(32'h000000FF, 32'h00000001, 1'b0, rs, rc, lat);
    checks++; if (lat !== 4) $display("FAIL basic_latency got %0d want 4", lat); else passed++;
    checks++; if (rs !== 32'h00000100) $display("FAIL basic_sum got %h want 00000100", rs); else passed++;
    checks++; if (rc !== 1'b0) $display("FAIL basic_cout got %b want 0", rc); else passed++;
    @(negedge clk);
    checks++; if (ir[0] !== 1'b1) $display("FAIL basic_return_idle got %b want 1", ir[0]); else passed++;
  endtask
  task automatic test_carry;
    logic [31:0] rs; logic rc; int lat;
    do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, rs, rc, lat);
    checks++; if (rs !== 32'h0) $display("FAIL carry_full_sum got %h want 00000000", rs); else passed++;
    checks++; if (rc !== 1'b1) $display("FAIL carry_full_cout got %b want 1", rc); else passed++;
    @(negedge clk);
    do_op(32'h80000000, 32'h80000000, 1'b0, rs, rc, lat);
    checks++; if (rs !== 32'h0) $display("FAIL carry_msb_sum got %h want 00000000", rs); else passed++;
    checks++; if (rc !== 1'b1) $display("FAIL carry_msb_cout got %b want 1", rc); else passed++;
    @(negedge clk);
  endtask
  task automatic test_backpressure;
    logic [31:0] rs; logic rc; int lat;
    out_ready = 1'b0;
    do_op(32'h12345678, 32'h11111111, 1'b0, rs, rc, lat);
    checks++; if (rs !== 32'h23456789) $display("FAIL bp_sum got %h want 23456789", rs); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++; if (s0 !== 32'h23456789) $display("FAIL bp_hold_sum got %h want 23456789", s0); else passed++;
      checks++; if (co[0] !== 1'b0) $display("FAIL bp_hold_cout got %b want 0", co[0]); else passed++;
      checks++; if (ir[0] !== 1'b0) $display("FAIL bp_in_ready got %b want 0", ir[0]); else passed++;
      checks++; if (ov[0] !== 1'b1) $display("FAIL bp_out_valid got %b want 1", ov[0]); else passed++;
      in_valid = (i == 1);
      a = 32'hDEADBEEF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (ov[0] !== 1'b0) $display("FAIL bp_release_valid got %b want 0", ov[0]); else passed++;
    checks++; if (ir[0] !== 1'b1) $display("FAIL bp_release_ready got %b want 1", ir[0]); else passed++;
    @(negedge clk);
    checks++; if (bz[0] !== 1'b0) $display("FAIL bp_dropped_busy got %b want 0", bz[0]); else passed++;
  endtask
  task automatic test_abort;
    logic [31:0] rs; logic rc; int lat;
    out_ready = 1'b1;
    a = 32'hFFFFFFFF; b = 32'h1; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ir[0] !== 1'b1) $display("FAIL abort_in_ready got %b want 1", ir[0]); else passed++;
    checks++; if (bz[0] !== 1'b0) $display("FAIL abort_busy got %b want 0", bz[0]); else passed++;
    checks++; if (s0 !== 32'h0) $display("FAIL abort_sum got %h want 0", s0); else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++; if (ov[0] !== 1'b0) $display("FAIL abort_no_valid got %b want 0", ov[0]); else passed++;
      @(negedge clk);
    end
    do_op(32'h1, 32'h2, 1'b0, rs, rc, lat);
    checks++; if (rs !== 32'h3) $display("FAIL abort_next_sum got %h want 3", rs); else passed++;
    checks++; if (lat !== 4) $display("FAIL abort_next_latency got %0d want 4", lat); else passed++;
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int done0 = 0, done1 = 0, cyc = 0, nlat;
    logic [32:0] e;
    logic [31:0] sv;
    bit seen0 = 0, seen1 = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q0.delete(); q1.delete();
    while (done0 < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      a = $urandom; b = $urandom; cin = 1'($urandom);
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      e = {1'b0, a} + {1'b0, b} + 33'(cin);
      if (ir[0] && in_valid) q0.push_back('{e, cyc});
      if (ir[1] && in_valid) q1.push_back('{e, cyc});
      for (int d = 0; d < 2; d++) begin
        if (ov[d]) begin
          checks++;
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            $display("FAIL rand_unexpected_valid dut%0d got valid want none pending", d);
            continue;
          end
          passed++;
          e = (d == 0) ? q0[0].exp : q1[0].exp;
          nlat = (d == 0) ? cyc - q0[0].acc : cyc - q1[0].acc;
          sv = (d == 0) ? s0 : s1;
          if (!(d == 0 ? seen0 : seen1)) begin
            checks++;
            if (nlat !== (d == 0 ? 5 : 2))
              $display("FAIL rand_latency dut%0d got %0d want %0d", d, nlat - 1, d == 0 ? 4 : 1);
            else passed++;
          end
          checks++;
          if ({co[d], sv} !== e) $display("FAIL rand_result dut%0d got %b_%h want %b_%h", d, co[d], sv, e[32], e[31:0]);
          else passed++;
          if (d == 0) seen0 = !out_ready; else seen1 = !out_ready;
          if (out_ready) begin
            if (d == 0) begin void'(q0.pop_front()); done0++; end
            else begin void'(q1.pop_front()); done1++; end
          end
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (done0 < 1000) $display("FAIL rand_budget got %0d ops want 1000", done0); else passed++;
    checks++; if (done1 <= done0) $display("FAIL rand_single_throughput got %0d ops want more than %0d", done1, done0); else passed++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
